branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Parametrised direct-mapped BTB + saturating-counter predictor for the 5-stage core.
//  Looked up combinationally with the IF-stage PC; produces predicted taken/target for n_PC select.
//  Trained from EX with the resolved outcome; flags mispredict and supplies the redirect PC.
//  Keeps saturating branch/mispredict performance counters.
// PARAMETERS
//  INST_ADDR_WIDTH  32  PC width
//  BTB_ENTRIES      16  table depth; power of 2, >=2; IDX_W=$clog2(BTB_ENTRIES)
//  CTR_WIDTH        2   direction counter width, >=1
//  PERF_WIDTH       32  performance counter width
// PORTS
//  cpu_clk          in   1      clock, all state on rising edge
//  cpu_rst_n        in   1      asynchronous, active-low reset
//  bp_enable        in   1      0: pred_taken forced 0; training continues
//  bp_flush_all     in   1      invalidate every entry on next edge
//  PC               in   IAW    IF-stage PC for lookup
//  pred_taken       out  1      predict taken (hit & counter MSB=1)
//  pred_target      out  IAW    stored target on hit, else PC+4
//  upd_valid        in   1      EX resolves a control-flow instruction this cycle
//  upd_is_jump      in   1      1: JAL/JALR (always taken); 0: conditional branch
//  upd_PC           in   IAW    PC of resolving instruction
//  upd_taken        in   1      actual direction
//  upd_target       in   IAW    actual taken target
//  upd_pred_taken   in   1      prediction carried down the pipe with the instruction
//  upd_pred_target  in   IAW    predicted next PC carried down the pipe
//  mispredict       out  1      combinational; drives flush_IF_ID/flush_ID_EX
//  redirect_PC      out  IAW    correct next PC when mispredict=1
//  num_branch       out  PERF_WIDTH  count of upd_valid cycles
//  num_mispredict   out  PERF_WIDTH  count of mispredict cycles
// BEHAVIOUR
//  - Index = PC[IDX_W+1:2]; tag = PC[IAW-1:IDX_W+2]; PC[1:0] ignored.
//  - Entry = {valid, tag, target, ctr}. Hit = valid & tag match.
//  - Lookup is combinational, zero latency. Table write visible at the next edge;
//    same-cycle lookup of an entry being written returns the OLD contents (no bypass).
//  - Reset (async): all valid=0, ctr=0, num_branch=num_mispredict=0; hence pred_taken=0,
//    pred_target=PC+4, mispredict=0 (while upd_valid=0). Reset mid-training discards all.
//  - actual_next = upd_taken ? upd_target : upd_PC+4;
//    pred_next   = upd_pred_taken ? upd_pred_target : upd_PC+4;
//    mispredict  = upd_valid & (actual_next != pred_next); redirect_PC = actual_next.
//  - Training on upd_valid (upd_PC index/tag):
//    hit, jump         -> target<=upd_target, ctr<=max
//    hit, branch       -> ctr +1 if taken else -1, saturating at 0/max; target<=upd_target if taken
//    miss, taken       -> allocate/overwrite: valid=1, tag, target, ctr = jump ? max : 1<<(CTR_WIDTH-1)
//    miss, not taken   -> no change
//  - bp_flush_all: all valid<=0 next edge; wins over a simultaneous update (update dropped);
//    perf counters still count that update.
//  - Perf counters: +1 per event, saturate at all-ones, never wrap.
//  - PC+4 arithmetic is modulo 2^IAW (wraps at top of address space).
//  - No stall input: stalled IF re-presents same PC, lookup is stateless.
// STRUCTURE
//  - Shared header (alongside riscv_defs.vh): entry field widths, CTR weak-taken/max
//    constants, opcode decodes used to form upd_is_jump.
//  - Sub-module bp_sat_counter (width param, inc/dec/load-max, saturating) for
//    direction counters; perf counters reuse a saturating increment.
//  - Table as flop arrays (valid needs async reset; tag/target/ctr may be unreset but valid-gated).
// TESTING
//  1 Reset then PC=0x100 -> pred_taken=0, pred_target=0x104; counters 0.
//  2 Branch @0x100 taken to 0x80, pred not-taken -> mispredict=1, redirect_PC=0x80;
//    next cycle PC=0x100 -> pred_taken=1 (ctr=2), pred_target=0x80; num_mispredict=1.
//  3 Same branch not-taken twice -> ctr 2->1->0; lookup pred_taken=0; third not-taken holds 0;
//    four taken -> saturates at 3.
//  4 Alias: BTB_ENTRIES=16, JAL @0x100 ->0x200, then JAL @0x140 ->0x300 -> 0x100 misses,
//    0x140 hits target 0x300; not-taken branch @0x180 (miss) leaves entry untouched.
//  5 bp_flush_all with simultaneous taken update @0x100 -> next cycle 0x100 misses;
//    num_branch still increments. bp_enable=0 on a trained hit -> pred_taken=0.
//  6 Assert cpu_rst_n low mid-sequence (no clock edge) -> pred_taken drops to 0 immediately;
//    PERF_WIDTH=2 bench: 5 mispredicts -> num_mispredict=3.

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch predictor: opcode decodes and table training operations.
package branch_target_predictor_pkg;

    // Instruction fetch is word aligned; PC[1:0] never participate in index or tag.
    localparam int unsigned PC_ALIGN_BITS = 2;

    typedef enum logic [6:0] {
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } rv_opcode_e;

    // EX uses this to form upd_is_jump from the resolving instruction's opcode.
    function automatic logic is_jump_opcode(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

    typedef enum logic [1:0] {
        TRAIN_NONE,
        TRAIN_HIT_JUMP,
        TRAIN_HIT_BRANCH,
        TRAIN_ALLOC
    } train_op_e;

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating direction-counter next-state logic: load-max has priority over inc/dec.
module bp_sat_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    input  logic             load_max,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (load_max) begin
            nxt = '1;
        end else if (inc && (cur != '1)) begin
            nxt = cur + WIDTH'(1);
        end else if (dec && (cur != '0)) begin
            nxt = cur - WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, combinational lookup,
// EX-stage training, mispredict/redirect generation and saturating performance counters.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned INST_ADDR_WIDTH = 32,
    parameter int unsigned BTB_ENTRIES     = 16,
    parameter int unsigned CTR_WIDTH       = 2,
    parameter int unsigned PERF_WIDTH      = 32
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       bp_enable,
    input  logic                       bp_flush_all,
    input  logic [INST_ADDR_WIDTH-1:0] PC,
    output logic                       pred_taken,
    output logic [INST_ADDR_WIDTH-1:0] pred_target,
    input  logic                       upd_valid,
    input  logic                       upd_is_jump,
    input  logic [INST_ADDR_WIDTH-1:0] upd_PC,
    input  logic                       upd_taken,
    input  logic [INST_ADDR_WIDTH-1:0] upd_target,
    input  logic                       upd_pred_taken,
    input  logic [INST_ADDR_WIDTH-1:0] upd_pred_target,
    output logic                       mispredict,
    output logic [INST_ADDR_WIDTH-1:0] redirect_PC,
    output logic [PERF_WIDTH-1:0]      num_branch,
    output logic [PERF_WIDTH-1:0]      num_mispredict
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = INST_ADDR_WIDTH - IDX_W - PC_ALIGN_BITS;
    localparam logic [INST_ADDR_WIDTH-1:0] PC_INC   = INST_ADDR_WIDTH'(4);
    localparam logic [CTR_WIDTH-1:0]       CTR_WEAK = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

    logic                       btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]           btb_tag    [BTB_ENTRIES];
    logic [INST_ADDR_WIDTH-1:0] btb_target [BTB_ENTRIES];
    logic [CTR_WIDTH-1:0]       btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [INST_ADDR_WIDTH-1:0] actual_next, pred_next;
    logic [CTR_WIDTH-1:0] ctr_nxt;
    train_op_e train_op;
    logic unused_align;

    assign unused_align = ^{PC[1:0], upd_PC[1:0]};

    assign lk_idx = PC[IDX_W+1:2];
    assign lk_tag = PC[INST_ADDR_WIDTH-1:IDX_W+2];
    assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

    assign pred_taken  = bp_enable & lk_hit & btb_ctr[lk_idx][CTR_WIDTH-1];
    assign pred_target = lk_hit ? btb_target[lk_idx] : PC + PC_INC;

    assign up_idx = upd_PC[IDX_W+1:2];
    assign up_tag = upd_PC[INST_ADDR_WIDTH-1:IDX_W+2];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    assign actual_next = upd_taken      ? upd_target      : upd_PC + PC_INC;
    assign pred_next   = upd_pred_taken ? upd_pred_target : upd_PC + PC_INC;
    assign mispredict  = upd_valid && (actual_next != pred_next);
    assign redirect_PC = actual_next;

    bp_sat_counter #(.WIDTH(CTR_WIDTH)) u_dir_ctr (
        .cur      (btb_ctr[up_idx]),
        .inc      (upd_taken),
        .dec      (~upd_taken),
        .load_max (upd_is_jump),
        .nxt      (ctr_nxt)
    );

    // A flush in the same cycle drops the update entirely.
    always_comb begin
        train_op = TRAIN_NONE;
        if (upd_valid && !bp_flush_all) begin
            if (up_hit) begin
                train_op = upd_is_jump ? TRAIN_HIT_JUMP : TRAIN_HIT_BRANCH;
            end else if (upd_taken || upd_is_jump) begin
                train_op = TRAIN_ALLOC;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= '0;
            end
        end else if (bp_flush_all) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else begin
            case (train_op)
                TRAIN_HIT_JUMP, TRAIN_HIT_BRANCH: btb_ctr[up_idx] <= ctr_nxt;
                TRAIN_ALLOC: begin
                    btb_valid[up_idx] <= 1'b1;
                    btb_ctr[up_idx]   <= upd_is_jump ? '1 : CTR_WEAK;
                end
                default: ;
            endcase
        end
    end

    // Tag and target need no reset: they are only observed through a valid entry.
    always_ff @(posedge cpu_clk) begin
        case (train_op)
            TRAIN_HIT_JUMP: btb_target[up_idx] <= upd_target;
            TRAIN_HIT_BRANCH: begin
                if (upd_taken) btb_target[up_idx] <= upd_target;
            end
            TRAIN_ALLOC: begin
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= upd_target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            num_branch     <= '0;
            num_mispredict <= '0;
        end else begin
            if (upd_valid && (num_branch != '1)) begin
                num_branch <= num_branch + PERF_WIDTH'(1);
            end
            if (mispredict && (num_mispredict != '1)) begin
                num_mispredict <= num_mispredict + PERF_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_branch_target_predictor;

    logic        cpu_clk, cpu_rst_n, bp_enable, bp_flush_all;
    logic [31:0] PC;
    logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
    logic [31:0] upd_PC, upd_target, upd_pred_target;
    logic        pred_taken, mispredict, pred_taken2, mispredict2;
    logic [31:0] pred_target, redirect_PC, pred_target2, redirect_PC2;
    logic [31:0] num_branch, num_mispredict;
    logic [1:0]  num_branch2, num_mispredict2;

    branch_target_predictor #(
        .INST_ADDR_WIDTH(32), .BTB_ENTRIES(16), .CTR_WIDTH(2), .PERF_WIDTH(32)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .bp_enable(bp_enable),
        .bp_flush_all(bp_flush_all), .PC(PC), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_valid(upd_valid), .upd_is_jump(upd_is_jump),
        .upd_PC(upd_PC), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_PC(redirect_PC),
        .num_branch(num_branch), .num_mispredict(num_mispredict)
    );

    // Narrow perf counters to exercise saturation.
    branch_target_predictor #(
        .INST_ADDR_WIDTH(32), .BTB_ENTRIES(16), .CTR_WIDTH(2), .PERF_WIDTH(2)
    ) dut2 (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .bp_enable(bp_enable),
        .bp_flush_all(bp_flush_all), .PC(PC), .pred_taken(pred_taken2),
        .pred_target(pred_target2), .upd_valid(upd_valid), .upd_is_jump(upd_is_jump),
        .upd_PC(upd_PC), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict2), .redirect_PC(redirect_PC2),
        .num_branch(num_branch2), .num_mispredict(num_mispredict2)
    );

    typedef enum {S_PT, S_TGT, S_MP, S_RED, S_NB, S_NM, S_NB2, S_NM2} sig_e;
    typedef struct {
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_got;
    int          checks = 0;
    int          failures = 0;

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    always @(negedge cpu_clk) begin
        while (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.sig)
                S_PT:    mon_got = {31'b0, pred_taken};
                S_TGT:   mon_got = pred_target;
                S_MP:    mon_got = {31'b0, mispredict};
                S_RED:   mon_got = redirect_PC;
                S_NB:    mon_got = num_branch;
                S_NM:    mon_got = num_mispredict;
                S_NB2:   mon_got = {30'b0, num_branch2};
                default: mon_got = {30'b0, num_mispredict2};
            endcase
            checks++;
            if (mon_got !== mon_e.exp) begin
                failures++;
                $display("FAIL %s at %0t: got %h expected %h", mon_e.sig.name(), $time,
                         mon_got, mon_e.exp);
            end
        end
    end

    task automatic chk(input sig_e s, input logic [31:0] v);
        exp_t e;
        e.sig = s;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    // Advance to just after the next rising edge and present a lookup with no update.
    task automatic cyc(input logic [31:0] pc);
        @(posedge cpu_clk);
        #1;
        PC           = pc;
        upd_valid    = 1'b0;
        bp_flush_all = 1'b0;
    endtask

    task automatic upd(input logic j, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_is_jump     = j;
        upd_PC          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cpu_rst_n = 1'b0; bp_enable = 1'b1; bp_flush_all = 1'b0; PC = '0;
        upd_valid = 1'b0; upd_is_jump = 1'b0; upd_PC = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        repeat (2) @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;

        // Reset state
        cyc(32'h100);
        chk(S_PT, 0); chk(S_TGT, 32'h104); chk(S_MP, 0); chk(S_NB, 0); chk(S_NM, 0);
        // Taken branch predicted not-taken; lookup still sees old contents
        cyc(32'h100); upd(0, 32'h100, 1, 32'h80, 0, 32'h104);
        chk(S_MP, 1); chk(S_RED, 32'h80); chk(S_PT, 0); chk(S_TGT, 32'h104);
        cyc(32'h100);
        chk(S_PT, 1); chk(S_TGT, 32'h80); chk(S_MP, 0); chk(S_NB, 1); chk(S_NM, 1);
        // Not-taken twice: ctr 2 -> 1 -> 0, third holds 0
        cyc(32'h100); upd(0, 32'h100, 0, 32'h0, 1, 32'h80);
        chk(S_MP, 1); chk(S_RED, 32'h104); chk(S_PT, 1);
        cyc(32'h100); upd(0, 32'h100, 0, 32'h0, 1, 32'h80);
        chk(S_MP, 1); chk(S_RED, 32'h104); chk(S_PT, 0); chk(S_TGT, 32'h80);
        cyc(32'h100); upd(0, 32'h100, 0, 32'h0, 0, 32'h104);
        chk(S_MP, 0); chk(S_PT, 0);
        cyc(32'h100);
        chk(S_PT, 0); chk(S_TGT, 32'h80); chk(S_NB, 4); chk(S_NM, 3);
        // Four taken from ctr 0: 1,2,3,3
        cyc(32'h100); upd(0, 32'h100, 1, 32'h80, 1, 32'h80); chk(S_MP, 0); chk(S_PT, 0);
        cyc(32'h100); upd(0, 32'h100, 1, 32'h80, 1, 32'h80); chk(S_PT, 0);
        cyc(32'h100); upd(0, 32'h100, 1, 32'h80, 1, 32'h80); chk(S_PT, 1);
        cyc(32'h100); upd(0, 32'h100, 1, 32'h80, 1, 32'h80); chk(S_PT, 1);
        // Saturated at 3: one not-taken still predicts taken, second does not
        cyc(32'h100); upd(0, 32'h100, 0, 32'h0, 0, 32'h104); chk(S_PT, 1);
        cyc(32'h100); upd(0, 32'h100, 0, 32'h0, 0, 32'h104); chk(S_PT, 1);
        cyc(32'h100);
        chk(S_PT, 0); chk(S_TGT, 32'h80); chk(S_NB, 10); chk(S_NM, 3);

        // Aliasing on index 0: 0x100, 0x140, 0x180
        cyc(32'h100); upd(1, 32'h100, 1, 32'h200, 0, 32'h104);
        chk(S_MP, 1); chk(S_RED, 32'h200);
        cyc(32'h100); upd(1, 32'h140, 1, 32'h300, 0, 32'h144);
        chk(S_MP, 1); chk(S_RED, 32'h300); chk(S_PT, 1); chk(S_TGT, 32'h200);
        cyc(32'h100); upd(0, 32'h180, 0, 32'h0, 0, 32'h184);
        chk(S_MP, 0); chk(S_PT, 0); chk(S_TGT, 32'h104);
        cyc(32'h140);
        chk(S_PT, 1); chk(S_TGT, 32'h300); chk(S_NB, 13); chk(S_NM, 5);
        cyc(32'h180);
        chk(S_PT, 0); chk(S_TGT, 32'h184);

        // Flush wins over a simultaneous allocating update
        cyc(32'h140); bp_flush_all = 1'b1; upd(0, 32'h100, 1, 32'h80, 1, 32'h80);
        chk(S_MP, 0); chk(S_PT, 1); chk(S_TGT, 32'h300);
        cyc(32'h100);
        chk(S_PT, 0); chk(S_TGT, 32'h104); chk(S_NB, 14); chk(S_NM, 5);
        cyc(32'h140);
        chk(S_PT, 0); chk(S_TGT, 32'h144);
        // bp_enable=0 on a trained hit
        cyc(32'h140); upd(1, 32'h140, 1, 32'h300, 0, 32'h144);
        chk(S_MP, 1); chk(S_RED, 32'h300);
        cyc(32'h140); bp_enable = 1'b0;
        chk(S_PT, 0); chk(S_TGT, 32'h300); chk(S_NB, 15); chk(S_NM, 6);
        cyc(32'h140); bp_enable = 1'b1;
        chk(S_PT, 1);

        // Asynchronous reset between edges
        cyc(32'h140); cpu_rst_n = 1'b0;
        chk(S_PT, 0); chk(S_TGT, 32'h144); chk(S_NB, 0); chk(S_NM, 0);
        chk(S_NB2, 0); chk(S_NM2, 0);
        cyc(32'hFFFF_FFFC); cpu_rst_n = 1'b1;
        chk(S_PT, 0); chk(S_TGT, 32'h0);

        // Five mispredicts: 32-bit counter reaches 5, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            cyc(32'h200); upd(0, 32'h200, 0, 32'h0, 1, 32'h400);
            chk(S_MP, 1); chk(S_RED, 32'h204);
        end
        cyc(32'h200);
        chk(S_MP, 0); chk(S_PT, 0); chk(S_NB, 5); chk(S_NM, 5); chk(S_NB2, 3); chk(S_NM2, 3);

        cyc(32'h0);
        cyc(32'h0);
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
